// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared constants and helpers for the pipeline hazard
// controller.
//   MULT_CYC_DEF / DIV_CYC_DEF : default MDU busy lengths.
//   T_*                        : Tuse/Tnew encodings; T_NEVER marks "operand never read".
//   md_op_e                    : MDU operation selector carried with E_md_start.
//   md_cnt_width()             : width of the MDU busy counter.
//   src_hazard()               : one source-vs-producer data-hazard test.
package pipe_ctrl_pkg;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  localparam logic [1:0] T_NOW   = 2'd0;
  localparam logic [1:0] T_ONE   = 2'd1;
  localparam logic [1:0] T_TWO   = 2'd2;
  localparam logic [1:0] T_NEVER = 2'd3;

  typedef enum logic {
    MD_MULT = 1'b0,
    MD_DIV  = 1'b1
  } md_op_e;

  // Smallest width that can hold the longer busy length without wrapping.
  function automatic int md_cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

  // A source stalls when it names a live producer whose result arrives later
  // than the consumer needs it. Register 0 is hard-wired and never stalls;
  // T_NEVER can never be less than any Tnew, so unused operands drop out.
  function automatic logic src_hazard(input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input logic [4:0] wa,
                                      input logic [1:0] tnew);
    return (src != 5'd0) && (src == wa) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- bundle of signals between the pipeline datapath and the
// hazard controller.
//   master : the datapath; drives decode/execute/memory stage info, reads
//            the write enables, bubble control and MDU status.
//   slave  : pipe_ctrl; the reverse directions.
// Signalling: there is no valid/ready pair here. Every input is a level that
// describes the instruction currently in that stage and is sampled every
// cycle; every output is meaningful every cycle. E_md_op is only looked at in
// a cycle where E_md_start is high.
interface pipe_ctrl_if;
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [1:0]  D_tuse_rs;
  logic [1:0]  D_tuse_rt;
  logic        D_md;
  logic [4:0]  E_wa;
  logic [4:0]  M_wa;
  logic [1:0]  E_tnew;
  logic [1:0]  M_tnew;
  logic        E_md_start;
  logic        E_md_op;
  logic        F_WE;
  logic        D_WE;
  logic        M_WE;
  logic        E_clr;
  logic        md_busy;
  logic        md_done;
  logic [31:0] stall_cnt;

  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_md,
    output E_wa, M_wa, E_tnew, M_tnew, E_md_start, E_md_op,
    input  F_WE, D_WE, M_WE, E_clr, md_busy, md_done, stall_cnt
  );

  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_md,
    input  E_wa, M_wa, E_tnew, M_tnew, E_md_start, E_md_op,
    output F_WE, D_WE, M_WE, E_clr, md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl_md_timer.sv
// md_timer -- models the multiply/divide unit's occupancy.
//   clk, reset  : clock, synchronous active-high reset.
//   start_i     : E-stage mult/div this cycle.
//   op_i        : 0 = mult, 1 = div (see md_op_e).
//   md_busy_o   : registered, high while an operation is in flight.
//   md_done_o   : high in the last busy cycle only.
module md_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic op_i,
  output logic md_busy_o,
  output logic md_done_o
);

  localparam int CW = md_cnt_width(MULT_CYC, DIV_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q;
  logic          load;

  // A start is accepted when the unit is idle or finishing this cycle, so a
  // back-to-back operation keeps md_busy high without a gap. A start in any
  // other busy cycle is dropped.
  always_comb begin
    cnt_d = cnt_q;
    load  = start_i && ((cnt_q == '0) || (cnt_q == CW'(1)));
    if (load) begin
      cnt_d = (md_op_e'(op_i) == MD_DIV) ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  assign md_busy_o = busy_q;
  assign md_done_o = (cnt_q == CW'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- stall/bubble controller for a 5-stage pipeline with an MDU.
//   clk, reset : clock, synchronous active-high reset.
//   bus        : pipe_ctrl_if.slave; hazard inputs from D/E/M stages,
//                F_WE/D_WE/M_WE/E_clr pipeline controls, MDU status and
//                the saturating stalled-cycle counter.
// Stall is purely combinational from the current inputs and MDU state; reset
// only clears this block's own registers, it does not force the stall.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic           clk,
  input  logic           reset,
  pipe_ctrl_if.slave     bus
);

  logic        data_stall;
  logic        md_stall;
  logic        stall;
  logic        md_busy;
  logic        md_done;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  md_timer #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_timer (
    .clk       (clk),
    .reset     (reset),
    .start_i   (bus.E_md_start),
    .op_i      (bus.E_md_op),
    .md_busy_o (md_busy),
    .md_done_o (md_done)
  );

  assign data_stall =
      src_hazard(bus.D_rs, bus.D_tuse_rs, bus.E_wa, bus.E_tnew) ||
      src_hazard(bus.D_rs, bus.D_tuse_rs, bus.M_wa, bus.M_tnew) ||
      src_hazard(bus.D_rt, bus.D_tuse_rt, bus.E_wa, bus.E_tnew) ||
      src_hazard(bus.D_rt, bus.D_tuse_rt, bus.M_wa, bus.M_tnew);

  // An MDU instruction in D must wait while the unit is busy, and also in
  // the cycle a new operation is being launched from E.
  assign md_stall = bus.D_md && (md_busy || bus.E_md_start);
  assign stall    = data_stall || md_stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.F_WE      = ~stall;
  assign bus.D_WE      = ~stall;
  assign bus.E_clr     = stall;
  assign bus.M_WE      = 1'b1;
  assign bus.md_busy   = md_busy;
  assign bus.md_done   = md_done;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .MULT_CYC (5),
    .DIV_CYC  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks;
  int errors;

  // Reference model: an MDU operation is described by the cycle it was
  // launched and the cycle it ends; busy covers (start, end], done is end.
  int     cyc;
  bit     md_valid;
  int     md_start;
  int     md_end;
  longint m_stall_cnt;

  function automatic bit m_busy();
    return md_valid && (cyc > md_start) && (cyc <= md_end);
  endfunction

  function automatic bit m_done();
    return md_valid && (cyc == md_end);
  endfunction

  function automatic bit hz(input logic [4:0] src, input logic [1:0] tuse,
                            input logic [4:0] wa, input logic [1:0] tnew);
    return (src != 0) && (src == wa) && (int'(tuse) < int'(tnew));
  endfunction

  function automatic bit m_stall();
    bit d;
    d = hz(bus.D_rs, bus.D_tuse_rs, bus.E_wa, bus.E_tnew) ||
        hz(bus.D_rs, bus.D_tuse_rs, bus.M_wa, bus.M_tnew) ||
        hz(bus.D_rt, bus.D_tuse_rt, bus.E_wa, bus.E_tnew) ||
        hz(bus.D_rt, bus.D_tuse_rt, bus.M_wa, bus.M_tnew);
    return d || (bus.D_md && (m_busy() || bus.E_md_start));
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.D_rs       = 5'd0;
    bus.D_rt       = 5'd0;
    bus.D_tuse_rs  = 2'd3;
    bus.D_tuse_rt  = 2'd3;
    bus.D_md       = 1'b0;
    bus.E_wa       = 5'd0;
    bus.M_wa       = 5'd0;
    bus.E_tnew     = 2'd0;
    bus.M_tnew     = 2'd0;
    bus.E_md_start = 1'b0;
    bus.E_md_op    = 1'b0;
  endtask

  // One cycle: compare outputs against the model mid-cycle, then advance the
  // model with the inputs seen at the rising edge.
  task automatic tick();
    bit s, b, d;
    @(negedge clk);
    s = m_stall();
    b = m_busy();
    d = m_done();
    chk1("F_WE", bus.F_WE, !s);
    chk1("D_WE", bus.D_WE, !s);
    chk1("E_clr", bus.E_clr, s);
    chk1("M_WE", bus.M_WE, 1'b1);
    chk1("md_busy", bus.md_busy, b);
    chk1("md_done", bus.md_done, d);
    chk32("stall_cnt", bus.stall_cnt, 32'(m_stall_cnt));
    @(posedge clk);
    if (reset) begin
      md_valid    = 1'b0;
      m_stall_cnt = 0;
    end else begin
      if (s && (m_stall_cnt < 64'h0000_0000_FFFF_FFFF)) m_stall_cnt++;
      if (bus.E_md_start && (!b || d)) begin
        md_valid = 1'b1;
        md_start = cyc;
        md_end   = cyc + (bus.E_md_op ? 10 : 5);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    md_valid    = 1'b0;
    md_start    = 0;
    md_end      = 0;
    m_stall_cnt = 0;

    // Bring the DUT out of its unknown power-up state before comparing.
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk1("rst_busy", bus.md_busy, 1'b0);
    chk1("rst_done", bus.md_done, 1'b0);
    chk32("rst_cnt", bus.stall_cnt, 32'd0);

    // E-stage producer of r5 one cycle too late for an immediate consumer.
    bus.D_rs = 5'd5; bus.D_tuse_rs = 2'd0; bus.E_wa = 5'd5; bus.E_tnew = 2'd1;
    #1;
    chk1("rs_e_fwe", bus.F_WE, 1'b0);
    chk1("rs_e_dwe", bus.D_WE, 1'b0);
    chk1("rs_e_clr", bus.E_clr, 1'b1);
    tick();
    chk32("rs_e_cnt", bus.stall_cnt, 32'd1);

    // Register 0 never stalls.
    drive_idle();
    bus.D_rt = 5'd0; bus.D_tuse_rt = 2'd0; bus.E_wa = 5'd0; bus.E_tnew = 2'd2;
    #1;
    chk1("r0_fwe", bus.F_WE, 1'b1);
    chk1("r0_clr", bus.E_clr, 1'b0);
    tick();

    // M-stage producer on rt, and an unused operand (Tuse = 3).
    drive_idle();
    bus.D_rt = 5'd9; bus.D_tuse_rt = 2'd1; bus.M_wa = 5'd9; bus.M_tnew = 2'd2;
    tick();
    bus.D_tuse_rt = 2'd3; bus.M_tnew = 2'd3;
    tick();

    // Multiply: busy cycles 1..5, done in 5, idle in 6.
    drive_idle();
    bus.E_md_start = 1'b1; bus.E_md_op = 1'b0;
    tick();
    drive_idle();
    for (int i = 1; i <= 5; i++) begin
      chk1("mult_busy", bus.md_busy, 1'b1);
      chk1("mult_done", bus.md_done, (i == 5));
      tick();
    end
    chk1("mult_idle", bus.md_busy, 1'b0);
    tick();

    // Divide with an MDU instruction waiting in D: 11 stalled cycles.
    do_reset();
    bus.E_md_start = 1'b1; bus.E_md_op = 1'b1; bus.D_md = 1'b1;
    tick();
    bus.E_md_start = 1'b0;
    repeat (10) tick();
    chk32("div_stall_total", bus.stall_cnt, 32'd11);
    tick();
    drive_idle();

    // Reset in busy cycle 3 of a divide aborts it without a done pulse.
    do_reset();
    bus.E_md_start = 1'b1; bus.E_md_op = 1'b1;
    tick();
    bus.E_md_start = 1'b0;
    repeat (2) tick();
    chk1("abort_pre_busy", bus.md_busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("abort_busy", bus.md_busy, 1'b0);
    chk1("abort_done", bus.md_done, 1'b0);
    chk32("abort_cnt", bus.stall_cnt, 32'd0);
    repeat (10) tick();

    // Divide launched in the last cycle of a multiply: no busy gap.
    bus.E_md_start = 1'b1; bus.E_md_op = 1'b0;
    tick();
    bus.E_md_start = 1'b0;
    repeat (4) tick();
    chk1("b2b_done", bus.md_done, 1'b1);
    bus.E_md_start = 1'b1; bus.E_md_op = 1'b1;
    tick();
    bus.E_md_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk1("b2b_busy", bus.md_busy, 1'b1);
      tick();
    end
    chk1("b2b_idle", bus.md_busy, 1'b0);

    // A start while busy (not last cycle) is ignored.
    bus.E_md_start = 1'b1; bus.E_md_op = 1'b0;
    tick();
    bus.E_md_op = 1'b1;
    repeat (2) tick();
    bus.E_md_start = 1'b0;
    repeat (6) tick();

    // Randomized traffic with small register numbers to force collisions.
    for (int n = 0; n < 600; n++) begin
      bus.D_rs       = 5'($urandom_range(0, 3));
      bus.D_rt       = 5'($urandom_range(0, 3));
      bus.D_tuse_rs  = 2'($urandom_range(0, 3));
      bus.D_tuse_rt  = 2'($urandom_range(0, 3));
      bus.D_md       = 1'($urandom_range(0, 1));
      bus.E_wa       = 5'($urandom_range(0, 3));
      bus.M_wa       = 5'($urandom_range(0, 3));
      bus.E_tnew     = 2'($urandom_range(0, 3));
      bus.M_tnew     = 2'($urandom_range(0, 3));
      bus.E_md_start = ($urandom_range(0, 5) == 0);
      bus.E_md_op    = 1'($urandom_range(0, 1));
      reset          = ($urandom_range(0, 79) == 0);
      tick();
    end
    reset = 1'b0;
    drive_idle();
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
